// File: rtl/bank_wr_if.sv
// bank_wr_if: requester handshakes and register-bank write strobes of the bank write-port arbiter
interface bank_wr_if #(parameter int CNT_W = 16);
  logic req_a, ack_a, req_b, ack_b, rw, busy;
  logic [4:0] addr_a, addr_b, wa;
  logic [31:0] data_a, data_b, din;
  logic [CNT_W-1:0] wr_count;
  modport master (output req_a, addr_a, data_a, req_b, addr_b, data_b,
                  input ack_a, ack_b, wa, din, rw, busy, wr_count);
  modport slave (input req_a, addr_a, data_a, req_b, addr_b, data_b,
                 output ack_a, ack_b, wa, din, rw, busy, wr_count);
endinterface

// File: rtl/bank_wr_arbiter.sv
// bank_wr_arbiter: clears upper bank registers after reset, then round-robins the single write port between A and B
module bank_wr_arbiter #(
  parameter int CLR_FIRST = 25,
  parameter int CLR_LAST = 31,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  bank_wr_if.slave bus
);
  typedef enum logic {CLEAR, RUN} state_t;
  localparam logic [4:0] FIRST = 5'(CLR_FIRST);
  localparam logic [4:0] LAST = 5'(CLR_LAST);
  state_t state, state_nx;
  logic [4:0] ptr;
  logic last_b, gnt_a, gnt_b;
  always_comb begin
    state_nx = state;
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (state == CLEAR) state_nx = (ptr == LAST) ? RUN : CLEAR;
    else begin
      gnt_a = bus.req_a && (!bus.req_b || last_b);
      gnt_b = bus.req_b && (!bus.req_a || !last_b);
    end
  end
  assign bus.ack_a = gnt_a;
  assign bus.ack_b = gnt_b;
  assign bus.busy = (state == CLEAR);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= CLEAR;
    else state <= state_nx;
  // wa/din hold their last value on idle RUN cycles; only rw drops
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= FIRST;
      last_b <= 1'b1;
      bus.rw <= 1'b0;
      bus.wa <= '0;
      bus.din <= '0;
      bus.wr_count <= '0;
    end else if (state == CLEAR) begin
      ptr <= ptr + 5'd1;
      bus.rw <= 1'b1;
      bus.wa <= ptr;
      bus.din <= '0;
    end else begin
      bus.rw <= gnt_a | gnt_b;
      if (gnt_a | gnt_b) begin
        bus.wa <= gnt_a ? bus.addr_a : bus.addr_b;
        bus.din <= gnt_a ? bus.data_a : bus.data_b;
        last_b <= gnt_b;
        bus.wr_count <= bus.wr_count + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_bank_wr_arbiter.sv
// tb_bank_wr_arbiter: directed steps with a write scoreboard for bank_wr_arbiter (CNT_W=4 to reach counter wrap)
module tb_bank_wr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;
  bank_wr_if #(.CNT_W(4)) bus();
  bank_wr_arbiter #(.CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push_clear;
    for (int r = 25; r <= 31; r++) exp_q.push_back({5'(r), 32'h0});
  endtask
  always @(posedge clk) begin
    #1;
    if (bus.rw) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL rw_unexpected observed wa=%0d din=%0h expected no write", bus.wa, bus.din);
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("wr_wa", 32'(bus.wa), 32'(mon_e[36:32]));
        chk("wr_din", bus.din, mon_e[31:0]);
      end
    end
  end
  initial begin
    bus.req_a = 1'b0; bus.addr_a = '0; bus.data_a = '0;
    bus.req_b = 1'b0; bus.addr_b = '0; bus.data_b = '0;
    #12;
    chk("rst_rw", 32'(bus.rw), 32'd0);
    chk("rst_wa", 32'(bus.wa), 32'd0);
    chk("rst_din", bus.din, 32'd0);
    chk("rst_ack", 32'({bus.ack_a, bus.ack_b}), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_cnt", 32'(bus.wr_count), 32'd0);
    push_clear();
    @(negedge clk) rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("clr_busy", 32'(bus.busy), 32'(k < 7));
    end
    chk("clr_cnt", 32'(bus.wr_count), 32'd0);
    bus.req_a = 1'b1; bus.addr_a = 5'd3; bus.data_a = 32'h1234;
    #1;
    chk("a1_ack_a", 32'(bus.ack_a), 32'd1);
    chk("a1_ack_b", 32'(bus.ack_b), 32'd0);
    exp_q.push_back({5'd3, 32'h1234});
    tick();
    bus.req_a = 1'b0;
    chk("a1_rw", 32'(bus.rw), 32'd1);
    chk("a1_cnt", 32'(bus.wr_count), 32'd1);
    tick();
    chk("idle_rw", 32'(bus.rw), 32'd0);
    chk("idle_wa_hold", 32'(bus.wa), 32'd3);
    chk("idle_din_hold", bus.din, 32'h1234);
    bus.req_b = 1'b1; bus.addr_b = 5'd0; bus.data_b = 32'hdead;
    #1;
    chk("b1_ack_b", 32'(bus.ack_b), 32'd1);
    chk("b1_ack_a", 32'(bus.ack_a), 32'd0);
    exp_q.push_back({5'd0, 32'hdead});
    tick();
    bus.req_b = 1'b0;
    bus.req_a = 1'b1; bus.addr_a = 5'd5; bus.data_a = 32'ha5a5;
    bus.req_b = 1'b1; bus.addr_b = 5'd6; bus.data_b = 32'hb6b6;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ack_a", 32'(bus.ack_a), 32'(i % 2 == 0));
      chk("rr_ack_b", 32'(bus.ack_b), 32'(i % 2 == 1));
      exp_q.push_back((i % 2 == 0) ? {5'd5, 32'ha5a5} : {5'd6, 32'hb6b6});
      tick();
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    chk("rr_cnt", 32'(bus.wr_count), 32'd6);
    bus.req_a = 1'b1; bus.addr_a = 5'd7; bus.data_a = 32'h77;
    #1;
    chk("pre_rst_ack", 32'(bus.ack_a), 32'd1);
    exp_q.push_back({5'd7, 32'h77});
    tick();
    bus.req_a = 1'b0;
    #1;
    rst = 1'b1;
    bus.req_b = 1'b1; bus.addr_b = 5'd9; bus.data_b = 32'h99;
    #1;
    chk("mid_rst_rw", 32'(bus.rw), 32'd0);
    chk("mid_rst_wa", 32'(bus.wa), 32'd0);
    chk("mid_rst_din", bus.din, 32'd0);
    chk("mid_rst_cnt", 32'(bus.wr_count), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd1);
    chk("mid_rst_ack", 32'(bus.ack_b), 32'd0);
    push_clear();
    @(negedge clk) rst = 1'b0;
    #1;
    chk("clr2_ack_b", 32'(bus.ack_b), 32'd0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("clr2_busy", 32'(bus.busy), 32'(k < 7));
      chk("clr2_ack_b", 32'(bus.ack_b), 32'(k == 7));
    end
    exp_q.push_back({5'd9, 32'h99});
    tick();
    bus.req_b = 1'b0;
    chk("b_pend_cnt", 32'(bus.wr_count), 32'd1);
    bus.req_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.addr_a = 5'(i);
      bus.data_a = 32'(i * 3 + 1);
      #1;
      chk("wrap_ack_a", 32'(bus.ack_a), 32'd1);
      exp_q.push_back({5'(i), 32'(i * 3 + 1)});
      tick();
      chk("wrap_cnt", 32'(bus.wr_count), 32'((2 + i) % 16));
    end
    bus.req_a = 1'b0;
    tick();
    tick();
    chk("final_rw", 32'(bus.rw), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
